// File: rtl/bp_cmd_link_arbiter.sv
// bp_cmd_link_arbiter: round-robin io/mem command arbiter onto one link, in-order response steering via source-ID FIFO.
// Optional perf counters enabled by BP_CMD_LINK_ARB_PERF_EN.
module bp_cmd_link_arbiter #(
  parameter int msg_width_p = 128,
  parameter int outstanding_p = 8,
  localparam int lg_outstanding_lp = $clog2(outstanding_p+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [msg_width_p-1:0]       io_cmd_i,
  input  logic                         io_cmd_v_i,
  output logic                         io_cmd_ready_o,
  input  logic [msg_width_p-1:0]       mem_cmd_i,
  input  logic                         mem_cmd_v_i,
  output logic                         mem_cmd_ready_o,
  output logic [msg_width_p-1:0]       link_cmd_o,
  output logic                         link_cmd_v_o,
  input  logic                         link_cmd_ready_i,
  input  logic [msg_width_p-1:0]       link_resp_i,
  input  logic                         link_resp_v_i,
  output logic                         link_resp_yumi_o,
  output logic [msg_width_p-1:0]       io_resp_o,
  output logic                         io_resp_v_o,
  input  logic                         io_resp_yumi_i,
  output logic [msg_width_p-1:0]       mem_resp_o,
  output logic                         mem_resp_v_o,
  input  logic                         mem_resp_yumi_i,
  output logic [lg_outstanding_lp-1:0] outstanding_o,
  output logic                         err_o
`ifdef BP_CMD_LINK_ARB_PERF_EN
  ,
  output logic [31:0]                  io_grant_cnt_o,
  output logic [31:0]                  mem_grant_cnt_o,
  output logic [31:0]                  full_stall_cnt_o
`endif
);
  localparam int lg_depth_lp = $clog2(outstanding_p);
  logic [outstanding_p-1:0] src_q;
  logic [lg_depth_lp-1:0] wr_ptr, rd_ptr;
  logic last_io, full, any_v, grant_io, grant_mem, can_issue, push, pop, head, nonempty;
  always_comb begin
    full = outstanding_o == lg_outstanding_lp'(outstanding_p);
    any_v = io_cmd_v_i | mem_cmd_v_i;
    // on a tie the source that did not win the last handshake goes next
    grant_io = io_cmd_v_i & (~mem_cmd_v_i | ~last_io);
    grant_mem = mem_cmd_v_i & ~grant_io;
    can_issue = reset_n_i & link_cmd_ready_i & ~full;
    link_cmd_v_o = reset_n_i & any_v & ~full;
    link_cmd_o = grant_io ? io_cmd_i : mem_cmd_i;
    io_cmd_ready_o = grant_io & can_issue;
    mem_cmd_ready_o = grant_mem & can_issue;
    push = link_cmd_v_o & link_cmd_ready_i;
    nonempty = outstanding_o != '0;
    head = src_q[rd_ptr];
    io_resp_v_o = reset_n_i & link_resp_v_i & nonempty & head;
    mem_resp_v_o = reset_n_i & link_resp_v_i & nonempty & ~head;
    link_resp_yumi_o = (io_resp_v_o & io_resp_yumi_i) | (mem_resp_v_o & mem_resp_yumi_i);
    pop = link_resp_yumi_o;
    io_resp_o = link_resp_i;
    mem_resp_o = link_resp_i;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      src_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding_o <= '0;
      last_io <= 1'b1;
      err_o <= 1'b0;
    end else begin
      if (push) begin
        src_q[wr_ptr] <= grant_io;
        wr_ptr <= wr_ptr + 1'b1;
        last_io <= grant_io;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop) outstanding_o <= outstanding_o + 1'b1;
      else if (pop & ~push) outstanding_o <= outstanding_o - 1'b1;
      if (link_resp_v_i & ~nonempty) err_o <= 1'b1;
    end
  end
`ifdef BP_CMD_LINK_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      io_grant_cnt_o <= '0;
      mem_grant_cnt_o <= '0;
      full_stall_cnt_o <= '0;
    end else begin
      if (push & grant_io) io_grant_cnt_o <= io_grant_cnt_o + 1'b1;
      if (push & grant_mem) mem_grant_cnt_o <= mem_grant_cnt_o + 1'b1;
      if (any_v & full) full_stall_cnt_o <= full_stall_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bp_cmd_link_arbiter.sv
// tb_bp_cmd_link_arbiter: directed plus randomized checks against a queue-based reference model.
module tb_bp_cmd_link_arbiter;
  localparam int W = 128;
  localparam int N = 8;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i = 1'b1;
  logic [W-1:0] io_cmd_i = '0, mem_cmd_i = '0, link_resp_i = '0;
  logic io_cmd_v_i = 0, mem_cmd_v_i = 0, link_cmd_ready_i = 0, link_resp_v_i = 0, io_resp_yumi_i = 0, mem_resp_yumi_i = 0;
  logic io_cmd_ready_o, mem_cmd_ready_o, link_cmd_v_o, link_resp_yumi_o, io_resp_v_o, mem_resp_v_o, err_o;
  logic [W-1:0] link_cmd_o, io_resp_o, mem_resp_o;
  logic [3:0] outstanding_o;
`ifdef BP_CMD_LINK_ARB_PERF_EN
  logic [31:0] io_grant_cnt_o, mem_grant_cnt_o, full_stall_cnt_o;
`endif
  bp_cmd_link_arbiter #(.msg_width_p(W), .outstanding_p(N)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .link_cmd_o(link_cmd_o), .link_cmd_v_o(link_cmd_v_o), .link_cmd_ready_i(link_cmd_ready_i),
    .link_resp_i(link_resp_i), .link_resp_v_i(link_resp_v_i), .link_resp_yumi_o(link_resp_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
`ifdef BP_CMD_LINK_ARB_PERF_EN
    , .io_grant_cnt_o(io_grant_cnt_o), .mem_grant_cnt_o(mem_grant_cnt_o), .full_stall_cnt_o(full_stall_cnt_o)
`endif
  );
  int vectors = 0, miscompares = 0;
  bit mq[$];
  bit m_last_io, m_err;
  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic model_reset();
    mq.delete();
    m_last_io = 1'b1;
    m_err = 1'b0;
  endtask
  task automatic set_in(bit iv, bit mv, bit rdy, bit rv, bit iy, bit my);
    io_cmd_v_i = iv; mem_cmd_v_i = mv; link_cmd_ready_i = rdy;
    link_resp_v_i = rv; io_resp_yumi_i = iy; mem_resp_yumi_i = my;
    io_cmd_i = rnd(); mem_cmd_i = rnd(); link_resp_i = rnd();
  endtask
  // compare every output with the model for the current inputs, then advance one clock
  task automatic step();
    bit full, gio, lv, ne, head, irv, mrv, yumi, push;
    #3;
    full = mq.size() == N;
    gio = io_cmd_v_i && (!mem_cmd_v_i || !m_last_io);
    lv = (io_cmd_v_i || mem_cmd_v_i) && !full;
    ne = mq.size() > 0;
    head = ne ? mq[0] : 1'b0;
    irv = link_resp_v_i && ne && head;
    mrv = link_resp_v_i && ne && !head;
    yumi = (irv && io_resp_yumi_i) || (mrv && mem_resp_yumi_i);
    push = lv && link_cmd_ready_i;
    chk("outstanding", outstanding_o, mq.size());
    chk("err", err_o, m_err);
    chk("link_cmd_v", link_cmd_v_o, lv);
    if (lv) chk("link_cmd", link_cmd_o, gio ? io_cmd_i : mem_cmd_i);
    chk("io_cmd_ready", io_cmd_ready_o, gio && link_cmd_ready_i && !full);
    chk("mem_cmd_ready", mem_cmd_ready_o, mem_cmd_v_i && !gio && link_cmd_ready_i && !full);
    chk("io_resp_v", io_resp_v_o, irv);
    chk("mem_resp_v", mem_resp_v_o, mrv);
    chk("link_resp_yumi", link_resp_yumi_o, yumi);
    if (irv) chk("io_resp", io_resp_o, link_resp_i);
    if (mrv) chk("mem_resp", mem_resp_o, link_resp_i);
    if (yumi) void'(mq.pop_front());
    if (push) begin
      mq.push_back(gio);
      m_last_io = gio;
    end
    if (link_resp_v_i && !ne) m_err = 1'b1;
    @(posedge clk_i); #1;
  endtask
  task automatic drive(bit iv, bit mv, bit rdy, bit rv, bit iy, bit my);
    set_in(iv, mv, rdy, rv, iy, my);
    step();
  endtask
  task automatic do_reset();
    set_in(1, 1, 1, 1, 1, 1);
    reset_n_i = 1'b0;
    #3;
    chk("rst_link_cmd_v", link_cmd_v_o, 0);
    chk("rst_io_ready", io_cmd_ready_o, 0);
    chk("rst_mem_ready", mem_cmd_ready_o, 0);
    chk("rst_io_resp_v", io_resp_v_o, 0);
    chk("rst_mem_resp_v", mem_resp_v_o, 0);
    chk("rst_yumi", link_resp_yumi_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    set_in(0, 0, 0, 0, 0, 0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask
  initial begin
    @(posedge clk_i); #1;
    do_reset();
    set_in(1, 0, 1, 0, 0, 0);
    io_cmd_i = 128'hA5;
    #1;
    chk("a5_v", link_cmd_v_o, 1);
    chk("a5_data", link_cmd_o, 128'hA5);
    chk("a5_ready", io_cmd_ready_o, 1);
    step();
    chk("a5_outstanding", outstanding_o, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 1, 0, 0, 0);
      #1;
      chk("rr_mem_ready", mem_cmd_ready_o, (i % 2) == 0);
      chk("rr_io_ready", io_cmd_ready_o, (i % 2) == 1);
      step();
    end
    chk("rr_outstanding", outstanding_o, 4);
    repeat (4) drive(1, 1, 1, 0, 0, 0);
    set_in(1, 1, 1, 0, 0, 0);
    #1;
    chk("full_v", link_cmd_v_o, 0);
    chk("full_io_ready", io_cmd_ready_o, 0);
    chk("full_mem_ready", mem_cmd_ready_o, 0);
    step();
    drive(1, 1, 1, 1, 0, 1);
    chk("full_pop_outstanding", outstanding_o, 7);
    set_in(1, 1, 1, 0, 0, 0);
    #1;
    chk("resume_v", link_cmd_v_o, 1);
    step();
    do_reset();
    set_in(0, 0, 0, 1, 1, 1);
    #1;
    chk("empty_yumi", link_resp_yumi_o, 0);
    chk("empty_io_v", io_resp_v_o, 0);
    chk("empty_mem_v", mem_resp_v_o, 0);
    step();
    chk("err_set", err_o, 1);
    repeat (3) drive(1, 0, 1, 0, 0, 0);
    chk("err_sticky", err_o, 1);
    do_reset();
    drive(0, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    set_in(0, 0, 0, 1, 1, 1);
    #1;
    chk("r0_mem_v", mem_resp_v_o, 1);
    chk("r0_io_v", io_resp_v_o, 0);
    step();
    repeat (2) begin
      set_in(0, 0, 0, 1, 0, 1);
      #1;
      chk("r1_io_v", io_resp_v_o, 1);
      chk("r1_hold_yumi", link_resp_yumi_o, 0);
      step();
    end
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk("order_drained", outstanding_o, 0);
    repeat (3) drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 1, 0);
    chk("pushpop_outstanding", outstanding_o, 3);
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
    end
    do_reset();
    repeat (3) drive(1, 1, 1, 0, 0, 0);
    set_in(1, 1, 1, 1, 1, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_link_cmd_v", link_cmd_v_o, 0);
    chk("async_io_ready", io_cmd_ready_o, 0);
    chk("async_mem_ready", mem_cmd_ready_o, 0);
    chk("async_io_resp_v", io_resp_v_o, 0);
    chk("async_mem_resp_v", mem_resp_v_o, 0);
    chk("async_yumi", link_resp_yumi_o, 0);
    chk("async_outstanding", outstanding_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("async_late_resp_err", err_o, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
